// File: rtl/microseq_pkg.sv
// Shared encodings for the microprogram sequencer: microword layout, op/cond codes, FSM states.
package microseq_pkg;

    // Width of the fixed (non-address) part of a microword.
    localparam int unsigned CTRL_W   = 22;

    localparam int unsigned OP_LSB   = 15;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned COND_LSB = 18;
    localparam int unsigned COND_W   = 3;
    localparam int unsigned INV_BIT  = 21;
    localparam int unsigned NEXT_LSB = 22;

    localparam logic [2:0] OP_NEXT  = 3'd0;
    localparam logic [2:0] OP_JUMP  = 3'd1;
    localparam logic [2:0] OP_JCOND = 3'd2;
    localparam logic [2:0] OP_CALL  = 3'd3;
    localparam logic [2:0] OP_RET   = 3'd4;
    localparam logic [2:0] OP_END   = 3'd5;

    localparam logic [2:0] COND_TRUE  = 3'd0;
    localparam logic [2:0] COND_POUT  = 3'd1;
    localparam logic [2:0] COND_ZERO  = 3'd2;
    localparam logic [2:0] COND_SIGN  = 3'd3;
    localparam logic [2:0] COND_OSR   = 3'd4;
    localparam logic [2:0] COND_OSL   = 3'd5;
    localparam logic [2:0] COND_EXT   = 3'd6;
    localparam logic [2:0] COND_FALSE = 3'd7;

    // ALU control bus, laid out to match microword bits [14:0].
    typedef struct packed {
        logic [3:0] v;
        logic [2:0] adr;
        logic       wr;
        logic       a;
        logic       pin;
        logic       m;
        logic [3:0] s;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    function automatic int unsigned uw_width(input int unsigned addr_w);
        return CTRL_W + addr_w;
    endfunction

endpackage

// File: rtl/microseq_stack.sv
// Micro-subroutine return stack: LIFO with registered pointer and full/empty flags.
module microseq_stack #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W-1:0]  sp_q;

    assign full     = (sp_q == PTR_W'(STACK_DEPTH));
    assign empty    = (sp_q == '0);
    assign pop_data = mem_q[IDX_W'(sp_q - PTR_W'(1))];

    // Overflowing push and underflowing pop are dropped; the caller flags the fault.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[IDX_W'(sp_q)] <= push_data;
            sp_q                <= sp_q + PTR_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - PTR_W'(1);
        end
    end

endmodule

// File: rtl/microprogram_sequencer.sv
// Microprogrammed control unit driving the register ALU from an external control store.
// Optional single-step support is enabled by defining MICROSEQ_STEP_EN.
module microprogram_sequencer
    import microseq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        entry,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic [ADDR_W-1:0]        uaddr,
    input  logic [CTRL_W+ADDR_W-1:0] uword,
    input  logic                     pout,
    input  logic                     osr,
    input  logic                     osl,
    input  logic [3:0]               r,
    input  logic                     ext_cond,
`ifdef MICROSEQ_STEP_EN
    input  logic                     step_mode,
    input  logic                     step,
`endif
    output logic [3:0]               S,
    output logic                     M,
    output logic                     Pin,
    output logic                     A,
    output logic                     wr,
    output logic [2:0]               adr,
    output logic [3:0]               v
);

    localparam int unsigned UW_W = uw_width(ADDR_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d, upc_inc;
    logic              done_d, fault_d;
    logic              exec_c;
    logic [OP_W-1:0]   op;
    logic [COND_W-1:0] cond;
    logic              cond_inv, cond_sel, taken;
    logic [ADDR_W-1:0] nxt;
    ctrl_t             ctrl;
    logic              push, pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;

    assign op       = uword[OP_LSB +: OP_W];
    assign cond     = uword[COND_LSB +: COND_W];
    assign cond_inv = uword[INV_BIT];
    assign nxt      = uword[NEXT_LSB +: ADDR_W];
    assign upc_inc  = upc_q + ADDR_W'(1);
    assign uaddr    = upc_q;

    // A microword executes only in RUN, and in step mode only on a step cycle.
`ifdef MICROSEQ_STEP_EN
    assign exec_c = (state_q == ST_RUN) && (!step_mode || step);
`else
    assign exec_c = (state_q == ST_RUN);
`endif

    assign ctrl = exec_c ? ctrl_t'(uword[$bits(ctrl_t)-1:0]) : '0;
    assign S    = ctrl.s;
    assign M    = ctrl.m;
    assign Pin  = ctrl.pin;
    assign A    = ctrl.a;
    assign wr   = ctrl.wr;
    assign adr  = ctrl.adr;
    assign v    = ctrl.v;

    // Condition select over the live ALU status.
    always_comb begin
        cond_sel = 1'b0;
        case (cond)
            COND_TRUE:  cond_sel = 1'b1;
            COND_POUT:  cond_sel = pout;
            COND_ZERO:  cond_sel = (r == 4'd0);
            COND_SIGN:  cond_sel = r[3];
            COND_OSR:   cond_sel = osr;
            COND_OSL:   cond_sel = osl;
            COND_EXT:   cond_sel = ext_cond;
            COND_FALSE: cond_sel = 1'b0;
            default:    cond_sel = 1'b0;
        endcase
    end

    assign taken = cond_sel ^ cond_inv;

    microseq_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .pop_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Next-state and next-address logic.
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        done_d  = 1'b0;
        fault_d = fault;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    upc_d   = entry;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (exec_c) begin
                    case (op)
                        OP_JUMP:  upc_d = nxt;
                        OP_JCOND: upc_d = taken ? nxt : upc_inc;
                        OP_CALL: begin
                            if (stk_full) begin
                                fault_d = 1'b1;
                                state_d = ST_FAULT;
                            end else begin
                                push  = 1'b1;
                                upc_d = nxt;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                fault_d = 1'b1;
                                state_d = ST_FAULT;
                            end else begin
                                pop   = 1'b1;
                                upc_d = stk_top;
                            end
                        end
                        OP_END: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                        default:  upc_d = upc_inc;
                    endcase
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            done    <= 1'b0;
            fault   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            done    <= done_d;
            fault   <= fault_d;
            busy    <= (state_d == ST_RUN);
        end
    end

    if (UW_W != CTRL_W + ADDR_W) begin : g_bad_width
        $error("microword width mismatch");
    end

endmodule

// File: doc/microprogram_sequencer.md
Name: microprogram_sequencer

Overview:
- Microprogrammed control unit directly upstream of the register ALU.
- Fetches microwords from an external, combinationally-read control store and drives the ALU control bus (S, M, Pin, A, wr, adr, v) once per clock.
- Sequences microprograms using ALU status: conditional jumps, a micro-subroutine stack and an end-of-program handshake.
- The instruction decoder starts each microprogram by supplying an entry address.

Parameters:
- ADDR_W, 6, control store address width (2^ADDR_W microwords).
- STACK_DEPTH, 4, micro-subroutine return stack entries (power of two, at least 2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin microprogram at entry; sampled only in IDLE.
- entry  in  ADDR_W  microprogram start address.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after an END microword executes.
- fault  out  1  sticky stack-error flag; cleared only by reset.
- uaddr  out  ADDR_W  control store address (equals uPC).
- uword  in  22+ADDR_W  microword at uaddr, same cycle.
- pout  in  1  ALU carry/propagate out.
- osr  in  1  ALU shift-right serial out.
- osl  in  1  ALU shift-left serial out.
- r  in  4  ALU result.
- ext_cond  in  1  external test input.
- S  out  4  ALU function select.
- M  out  1  ALU mode select.
- Pin  out  1  ALU carry in.
- A  out  1  register A source select.
- wr  out  1  register-file write enable.
- adr  out  3  register-file address.
- v  out  4  register load/shift controls.

Behaviour:
- Microword fields:
  - S[3:0], M[4], Pin[5], A[6], wr[7], adr[10:8], v[14:11].
  - op[17:15], cond[20:18], cond_inv[21], next[22+ADDR_W-1:22].
- op encoding: 0 NEXT, 1 JUMP, 2 JCOND, 3 CALL, 4 RET, 5 END; 6 and 7 are treated as NEXT.
- cond encoding: 0 true, 1 pout, 2 (r==0), 3 r[3], 4 osr, 5 osl, 6 ext_cond, 7 false. Taken condition = selected ^ cond_inv.
- States: IDLE, RUN, FAULT.
- Reset: state IDLE, uPC=0, stack pointer=0, stack contents=0, done=0, fault=0.
- Control outputs:
  - In RUN: combinationally equal to the uword fields.
  - In IDLE and FAULT: all zero (ALU holds, no write).
- IDLE:
  - start=1 loads uPC<=entry and moves to RUN.
  - The first microword executes the following cycle.
- RUN, one microword per cycle; next uPC:
  - NEXT: uPC+1, wrapping from 2^ADDR_W-1 to 0.
  - JUMP: next.
  - JCOND: next if taken, else uPC+1.
  - CALL: push uPC+1, go to next.
  - RET: pop into uPC.
  - END: go to IDLE; done=1 in the following cycle only; uPC unchanged.
- Conditions are evaluated on the ALU inputs present in the same cycle as the microword (pre-edge values).
- Stack errors:
  - CALL with stack full or RET with stack empty: no push/pop, fault<=1, move to FAULT.
  - The faulting microword's controls are still driven for that cycle.
  - FAULT is left only by reset.
- start while busy or in FAULT is ignored.
- done and start in the same cycle (IDLE): start is accepted and done still pulses.
- busy is registered: equals (state==RUN).
- Reset mid-program aborts immediately; outputs are zero asynchronously.

Optional Feature:
- Macro: MICROSEQ_STEP_EN.
- Defined:
  - Adds inputs step_mode (1) and step (1).
  - When step_mode=1 in RUN, a microword executes only in a cycle with step=1.
  - In non-step cycles, uPC and the stack hold and the control outputs are forced to zero.
  - step_mode=0 gives normal free-running behaviour.
- Not defined: the ports are absent and behaviour is free-running only.

Decomposition:
- Shared package microseq_pkg holds:
  - op and cond localparam encodings;
  - field bit positions;
  - the UW_W=22+ADDR_W width formula;
  - state encoding.
- One sub-module, microseq_stack: LIFO with push, pop, full, empty and a registered pointer, parameterised by STACK_DEPTH and ADDR_W.
- Condition mux and next-address logic stay in the top level.

Test Plan:
- Reset then start=1, entry=0x10; store 0x10 NEXT (S=4'h9, wr=1, adr=3), 0x11 END → uaddr 0x10 then 0x11; S=9, wr=1 during cycle 1; done pulses in cycle 3; busy drops.
- JCOND cond=2, cond_inv=0 at 0x20, next=0x30: r=0 → uaddr 0x30; r=4'h5 → uaddr 0x21.
- CALL at 0x05 (next=0x3C), 0x3C RET → uaddr sequence 0x05, 0x3C, 0x06.
- Five nested CALLs with STACK_DEPTH=4 → fault=1 after the fifth; outputs all zero afterwards; start ignored until reset.
- NEXT at 0x3F (ADDR_W=6) → uaddr wraps to 0x00.
- reset low mid-program → S, v, wr, busy immediately zero; after release, start=1, entry=0x02 runs normally.
